sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, word address width toward the SDRAM controller.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter MAX_PEND, default 8, maximum outstanding reads tracked (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports rN_address  input  ADDR_W  requester N address (N=0,1, one port each).
REQ-007 SHALL have ports rN_read / rN_write  input  1 each  requester N command strobes.
REQ-008 SHALL have ports rN_writedata  input  DATA_W  and rN_byteenable  input  DATA_W/8.
REQ-009 SHALL have ports rN_waitrequest  output  1  stall to requester N.
REQ-010 SHALL have ports rN_readdata  output  DATA_W  and rN_readdatavalid  output  1.
REQ-011 SHALL have ports m_address, m_read, m_write, m_writedata, m_byteenable  outputs  (widths as above)  command to the SDRAM controller.
REQ-012 SHALL have ports m_waitrequest  input  1, m_readdata  input  DATA_W, m_readdatavalid  input  1.
REQ-013 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-014 SHALL share one pipelined Avalon-MM master port between two Avalon-MM requesters, with variable-latency reads.
REQ-015 SHALL implement FSM states IDLE, OWN0, OWN1.
REQ-016 IDLE: a requester is eligible if (read or write) and not (read-only command while tag FIFO full); if exactly one is eligible, next state is its OWNn.
REQ-017 IDLE, both eligible: grant the requester not granted last (round-robin pointer); pointer updates on every grant.
REQ-018 IDLE: m_read = m_write = 0; both rN_waitrequest = 1.
REQ-019 OWNn: m_* command outputs SHALL be combinational copies of rN_* inputs; rN_waitrequest = m_waitrequest; other requester's waitrequest = 1.
REQ-020 OWNn: command accepted when (m_read or m_write) and !m_waitrequest; on acceptance return to IDLE (one-cycle bubble between commands, one command per grant).
REQ-021 OWNn: if owner deasserts both strobes without acceptance, return to IDLE (no transfer).
REQ-022 Grant latency: request first seen in IDLE at cycle T -> m_read/m_write asserted at T+1.
REQ-023 SHALL keep a tag FIFO of MAX_PEND 1-bit requester IDs; push owner ID on each accepted read; writes push nothing.
REQ-024 On m_readdatavalid, pop FIFO head and assert rN_readdatavalid for that ID in the same cycle (combinational, zero added latency); other valid = 0.
REQ-025 rN_readdata SHALL equal m_readdata for both requesters at all times.
REQ-026 Push and pop in the same cycle: count unchanged, order preserved; pushing when full SHALL be impossible by REQ-016.
REQ-027 Full FIFO: reads held off (waitrequest high) until a pop; writes still granted.
REQ-028 m_readdatavalid with empty FIFO: no rN_readdatavalid, no pop, err set to 1 and held until rst.
REQ-029 In-order return assumed from the SDRAM controller; returns routed strictly FIFO order.
REQ-030 Read and write both asserted by a requester: treated as read for FIFO/eligibility purposes, both copied to master.

Reset
REQ-031 On rst: state IDLE, pointer favours r0, FIFO empty (count 0), err = 0.
REQ-032 During/after rst: m_read = m_write = 0, rN_waitrequest = 1, rN_readdatavalid = 0.
REQ-033 Reset mid-operation discards pending tags and any granted but unaccepted command; the surrounding system resets the SDRAM controller with it.

Verification
REQ-034 Single read: r0_read, addr 0x10, m_waitrequest 0, data 0xDEADBEEF returned 3 cycles later -> m_read one cycle after request, r0_readdatavalid 1 cycle with 0xDEADBEEF, r1_readdatavalid 0.
REQ-035 Contention: r0 and r1 write continuously -> master accepts alternating r0, r1, r0, r1; each command reaches m_* exactly once.
REQ-036 Interleaved returns: reads r0,r1,r1,r0 accepted, then 4 readdatavalids -> valids route r0,r1,r1,r0 in order.
REQ-037 Full: 8 r0 reads accepted with no return -> 9th read stalled, r1 write still accepted; one return -> 9th read granted.
REQ-038 Spurious return: m_readdatavalid with empty FIFO -> err=1, no rN_readdatavalid; err clears only on rst.
REQ-039 Reset with 3 reads pending -> count 0, all outputs at REQ-032 values the next cycle.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one pipelined Avalon-MM master between two requesters.
// Round-robin grant from IDLE, one command per grant, and a tag FIFO that
// routes variable-latency read returns back to the requester that issued them.
//
// Handshake: a command transfers on a rising edge where the owner's strobe
// (read or write) is high and waitrequest is low. Requesters hold command
// fields stable while their waitrequest is high. Read data returns with
// readdatavalid in the same order the reads were accepted.
module sdram_arbiter #(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester 0
  input  logic [ADDR_W-1:0]     r0_address,
  input  logic                  r0_read,
  input  logic                  r0_write,
  input  logic [DATA_W-1:0]     r0_writedata,
  input  logic [DATA_W/8-1:0]   r0_byteenable,
  output logic                  r0_waitrequest,
  output logic [DATA_W-1:0]     r0_readdata,
  output logic                  r0_readdatavalid,
  // requester 1
  input  logic [ADDR_W-1:0]     r1_address,
  input  logic                  r1_read,
  input  logic                  r1_write,
  input  logic [DATA_W-1:0]     r1_writedata,
  input  logic [DATA_W/8-1:0]   r1_byteenable,
  output logic                  r1_waitrequest,
  output logic [DATA_W-1:0]     r1_readdata,
  output logic                  r1_readdatavalid,
  // master toward the SDRAM controller
  output logic [ADDR_W-1:0]     m_address,
  output logic                  m_read,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  output logic [DATA_W/8-1:0]   m_byteenable,
  input  logic                  m_waitrequest,
  input  logic [DATA_W-1:0]     m_readdata,
  input  logic                  m_readdatavalid,
  // status
  output logic [1:0]            dbg_state,
  output logic                  err
);

  localparam int PTR_W = $clog2(MAX_PEND);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  rr_q, rr_d;          // 1: r1 wins the next tie
  logic [MAX_PEND-1:0]   tag_q, tag_d;        // requester ID per pending read
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  err_q, err_d;

  logic fifo_full, fifo_empty;
  logic elig0, elig1;
  logic accept, push, pop, head_id;

  assign fifo_full  = (count_q == (PTR_W+1)'(MAX_PEND));
  assign fifo_empty = (count_q == '0);

  // A read (including read+write) cannot be granted while no tag slot is free.
  assign elig0 = (r0_read | r0_write) & ~(r0_read & fifo_full);
  assign elig1 = (r1_read | r1_write) & ~(r1_read & fifo_full);

  assign accept  = (state_q != IDLE) & (m_read | m_write) & ~m_waitrequest;
  assign push    = accept & m_read;
  assign pop     = m_readdatavalid & ~fifo_empty;
  assign head_id = tag_q[rd_ptr_q];

  assign r0_readdata = m_readdata;
  assign r1_readdata = m_readdata;
  assign dbg_state   = state_q;
  assign err         = err_q;

  // Command path: owner's inputs pass straight through; everyone else stalls.
  always_comb begin
    m_address      = (state_q == OWN1) ? r1_address    : r0_address;
    m_writedata    = (state_q == OWN1) ? r1_writedata  : r0_writedata;
    m_byteenable   = (state_q == OWN1) ? r1_byteenable : r0_byteenable;
    m_read         = 1'b0;
    m_write        = 1'b0;
    r0_waitrequest = 1'b1;
    r1_waitrequest = 1'b1;
    if (!rst) begin
      case (state_q)
        OWN0: begin
          m_read         = r0_read;
          m_write        = r0_write;
          r0_waitrequest = m_waitrequest;
        end
        OWN1: begin
          m_read         = r1_read;
          m_write        = r1_write;
          r1_waitrequest = m_waitrequest;
        end
        default: ;
      endcase
    end
  end

  // Return path: the FIFO head names the requester that gets this beat.
  always_comb begin
    r0_readdatavalid = pop & ~head_id & ~rst;
    r1_readdatavalid = pop &  head_id & ~rst;
  end

  // Next-state: grant FSM, round-robin pointer, tag FIFO and sticky error.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (elig0 && elig1) begin
          state_d = rr_q ? OWN1 : OWN0;
          rr_d    = ~rr_q;
        end else if (elig0) begin
          state_d = OWN0;
          rr_d    = 1'b1;
        end else if (elig1) begin
          state_d = OWN1;
          rr_d    = 1'b0;
        end
      end
      OWN0, OWN1: begin
        // One command per grant; an abandoned request also releases the bus.
        if (accept || !(m_read || m_write)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      tag_d[wr_ptr_q] = (state_q == OWN1);
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase

    if (m_readdatavalid && fifo_empty) err_d = 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios with a scoreboard of expected
// master-side commands and expected read-return routing.
module tb_sdram_arbiter;

  localparam int ACC_W = 63;  // {read, write, address[25], byteenable[4], data[32]}
  localparam int RET_W = 34;  // {r0_valid, r1_valid, data[32]}

  logic        clk = 1'b0;
  logic        rst;
  logic [24:0] r0_address, r1_address, m_address;
  logic        r0_read, r0_write, r1_read, r1_write;
  logic [31:0] r0_writedata, r1_writedata, m_writedata;
  logic [3:0]  r0_byteenable, r1_byteenable, m_byteenable;
  logic        r0_waitrequest, r1_waitrequest;
  logic [31:0] r0_readdata, r1_readdata, m_readdata;
  logic        r0_readdatavalid, r1_readdatavalid;
  logic        m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [1:0]  dbg_state;
  logic        err;

  int n_cmp = 0;
  int n_mis = 0;

  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] acc_q[$];
  logic [RET_W-1:0] exp_ret_q[$];
  logic [RET_W-1:0] ret_q[$];

  sdram_arbiter #(.ADDR_W(25), .DATA_W(32), .MAX_PEND(8)) dut (
    .clk(clk), .rst(rst),
    .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write),
    .r0_writedata(r0_writedata), .r0_byteenable(r0_byteenable),
    .r0_waitrequest(r0_waitrequest), .r0_readdata(r0_readdata),
    .r0_readdatavalid(r0_readdatavalid),
    .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write),
    .r1_writedata(r1_writedata), .r1_byteenable(r1_byteenable),
    .r1_waitrequest(r1_waitrequest), .r1_readdata(r1_readdata),
    .r1_readdatavalid(r1_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .dbg_state(dbg_state), .err(err)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Capture accepted master commands and routed returns, away from the edge.
  always @(negedge clk) begin
    if (!rst) begin
      if ((m_read || m_write) && !m_waitrequest)
        acc_q.push_back({m_read, m_write, m_address, m_byteenable, m_writedata});
      if (r0_readdatavalid || r1_readdatavalid)
        ret_q.push_back({r0_readdatavalid, r1_readdatavalid, r0_readdata});
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [3:0] be_of(input int n);
    return (n == 0) ? 4'h3 : 4'hC;
  endfunction

  task automatic set_req(input int n, input logic rd, input logic wr,
                         input logic [24:0] a, input logic [31:0] d);
    if (n == 0) begin
      r0_read = rd; r0_write = wr; r0_address = a; r0_writedata = d; r0_byteenable = be_of(0);
    end else begin
      r1_read = rd; r1_write = wr; r1_address = a; r1_writedata = d; r1_byteenable = be_of(1);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  // Strobes are left asserted; the caller changes or clears them.
  task automatic req_cmd(input int n, input logic rd, input logic wr,
                         input logic [24:0] a, input logic [31:0] d, output bit ok);
    set_req(n, rd, wr, a, d);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (((n == 0) ? r0_waitrequest : r1_waitrequest) == 1'b0) ok = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic ret(input logic [31:0] d);
    m_readdatavalid = 1'b1;
    m_readdata      = d;
    @(posedge clk); #1;
    m_readdatavalid = 1'b0;
  endtask

  task automatic pulse_reset();
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_q.delete(); ret_q.delete(); exp_q.delete(); exp_ret_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1, 0, 25'h5, 32'h0);   // request during reset must be ignored
    m_readdatavalid = 1'b1;           // as must a return
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (m_read !== 1'b0 || m_write !== 1'b0) begin
      n_mis++; $display("FAIL reset_cmd: m_read=%b m_write=%b, expected 0 0", m_read, m_write);
    end
    n_cmp++;
    if (r0_waitrequest !== 1'b1 || r1_waitrequest !== 1'b1) begin
      n_mis++; $display("FAIL reset_wait: r0=%b r1=%b, expected 1 1", r0_waitrequest, r1_waitrequest);
    end
    n_cmp++;
    if (r0_readdatavalid !== 1'b0 || r1_readdatavalid !== 1'b0) begin
      n_mis++; $display("FAIL reset_rdv: r0=%b r1=%b, expected 0 0", r0_readdatavalid, r1_readdatavalid);
    end
    @(posedge clk); #1;
    m_readdatavalid = 1'b0;
    set_req(0, 0, 0, '0, '0);
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0 || dbg_state !== 2'd0) begin
      n_mis++; $display("FAIL reset_state: err=%b state=%0d, expected 0 0", err, dbg_state);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    acc_q.delete(); ret_q.delete();
  endtask

  task automatic test_single_read();
    set_req(0, 1, 0, 25'h10, 32'h0);
    @(negedge clk);  // cycle T: arbiter still IDLE
    n_cmp++;
    if (m_read !== 1'b0 || r0_waitrequest !== 1'b1) begin
      n_mis++; $display("FAIL single_idle: m_read=%b r0_wait=%b, expected 0 1", m_read, r0_waitrequest);
    end
    @(posedge clk); #1;
    @(negedge clk);  // cycle T+1: command on master
    n_cmp++;
    if (m_read !== 1'b1 || m_address !== 25'h10 || r0_waitrequest !== 1'b0 || r1_waitrequest !== 1'b1) begin
      n_mis++; $display("FAIL single_grant: m_read=%b addr=%h r0_wait=%b r1_wait=%b, expected 1 010 0 1",
                        m_read, m_address, r0_waitrequest, r1_waitrequest);
    end
    @(posedge clk); #1;
    set_req(0, 0, 0, '0, '0);
    repeat (2) begin @(posedge clk); #1; end
    m_readdatavalid = 1'b1;
    m_readdata      = 32'hDEADBEEF;
    @(negedge clk);
    n_cmp++;
    if (r0_readdatavalid !== 1'b1 || r1_readdatavalid !== 1'b0) begin
      n_mis++; $display("FAIL single_route: r0v=%b r1v=%b, expected 1 0", r0_readdatavalid, r1_readdatavalid);
    end
    n_cmp++;
    if (r0_readdata !== 32'hDEADBEEF || r1_readdata !== 32'hDEADBEEF) begin
      n_mis++; $display("FAIL single_data: r0=%h r1=%h, expected deadbeef", r0_readdata, r1_readdata);
    end
    @(posedge clk); #1;
    m_readdatavalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (r0_readdatavalid !== 1'b0 || err !== 1'b0) begin
      n_mis++; $display("FAIL single_after: r0v=%b err=%b, expected 0 0", r0_readdatavalid, err);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_writes(input int n, input int cnt, input logic [24:0] base);
    bit ok;
    for (int i = 0; i < cnt; i++) begin
      req_cmd(n, 1'b0, 1'b1, base + 25'(i), 32'hA000_0000 + 32'(n * 256 + i), ok);
      n_cmp++;
      if (!ok) begin
        n_mis++; $display("FAIL contention_timeout: r%0d write %0d not accepted, expected accept", n, i);
      end
    end
    set_req(n, 0, 0, '0, '0);
  endtask

  task automatic test_contention();
    logic [ACC_W-1:0] e;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < 2; n++)
        exp_q.push_back({1'b0, 1'b1, 25'((n == 0 ? 25'h100 : 25'h200) + 25'(i)), be_of(n),
                         32'hA000_0000 + 32'(n * 256 + i)});
    end
    fork
      run_writes(0, 4, 25'h100);
      run_writes(1, 4, 25'h200);
    join
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (acc_q.size() != exp_q.size()) begin
      n_mis++; $display("FAIL contention_count: got %0d commands, expected %0d", acc_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && acc_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (acc_q[0] !== e) begin
        n_mis++; $display("FAIL contention_order: got %h, expected %h", acc_q[0], e);
      end
      void'(acc_q.pop_front());
    end
  endtask

  task automatic test_interleave();
    bit ok;
    int ids[4] = '{0, 1, 1, 0};
    logic [RET_W-1:0] e;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      req_cmd(ids[i], 1'b1, 1'b0, 25'h300 + 25'(i), 32'h0, ok);
      set_req(ids[i], 0, 0, '0, '0);
      n_cmp++;
      if (!ok) begin
        n_mis++; $display("FAIL interleave_issue: read %0d not accepted, expected accept", i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      d = $urandom();
      exp_ret_q.push_back({ids[i] == 0, ids[i] == 1, d});
      ret(d);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (ret_q.size() != 4) begin
      n_mis++; $display("FAIL interleave_count: got %0d returns, expected 4", ret_q.size());
    end
    while (exp_ret_q.size() > 0 && ret_q.size() > 0) begin
      e = exp_ret_q.pop_front();
      n_cmp++;
      if (ret_q[0] !== e) begin
        n_mis++; $display("FAIL interleave_route: got %h, expected %h", ret_q[0], e);
      end
      void'(ret_q.pop_front());
    end
  endtask

  task automatic test_full();
    bit ok;
    bit stalled;
    logic [ACC_W-1:0] e;
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      req_cmd(0, 1'b1, 1'b0, 25'h400 + 25'(i), 32'h0, ok);
      set_req(0, 0, 0, '0, '0);
      exp_q.push_back({1'b1, 1'b0, 25'h400 + 25'(i), be_of(0), 32'h0});
      n_cmp++;
      if (!ok) begin
        n_mis++; $display("FAIL full_fill: read %0d not accepted, expected accept", i);
      end
    end
    set_req(0, 1, 0, 25'h408, 32'h0);   // ninth read: must stall
    req_cmd(1, 1'b0, 1'b1, 25'h500, 32'h55, ok);
    set_req(1, 0, 0, '0, '0);
    exp_q.push_back({1'b0, 1'b1, 25'h500, be_of(1), 32'h55});
    n_cmp++;
    if (!ok) begin
      n_mis++; $display("FAIL full_write: r1 write stalled, expected accept while full");
    end
    stalled = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (r0_waitrequest !== 1'b1 || m_read !== 1'b0) stalled = 1'b0;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!stalled) begin
      n_mis++; $display("FAIL full_stall: ninth read got through, expected waitrequest held");
    end
    ret(32'hF0F0_0000);
    exp_q.push_back({1'b1, 1'b0, 25'h408, be_of(0), 32'h0});
    req_cmd(0, 1'b1, 1'b0, 25'h408, 32'h0, ok);
    set_req(0, 0, 0, '0, '0);
    n_cmp++;
    if (!ok) begin
      n_mis++; $display("FAIL full_release: ninth read not granted after pop, expected accept");
    end
    for (int i = 0; i < 8; i++) ret(32'hF0F0_0001 + 32'(i));
    @(posedge clk); #1;
    n_cmp++;
    if (acc_q.size() != exp_q.size() || ret_q.size() != 9 || err !== 1'b0) begin
      n_mis++; $display("FAIL full_totals: cmds=%0d rets=%0d err=%b, expected %0d 9 0",
                        acc_q.size(), ret_q.size(), err, exp_q.size());
    end
    while (exp_q.size() > 0 && acc_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (acc_q[0] !== e) begin
        n_mis++; $display("FAIL full_order: got %h, expected %h", acc_q[0], e);
      end
      void'(acc_q.pop_front());
    end
    n_cmp++;
    if (ret_q.size() > 0 && ret_q[$][RET_W-1 -: 2] !== 2'b10) begin
      n_mis++; $display("FAIL full_route: last return flags %b, expected 10", ret_q[$][RET_W-1 -: 2]);
    end
  endtask

  task automatic test_spurious();
    pulse_reset();
    m_readdatavalid = 1'b1;
    m_readdata      = 32'h7777_7777;
    @(negedge clk);
    n_cmp++;
    if (r0_readdatavalid !== 1'b0 || r1_readdatavalid !== 1'b0) begin
      n_mis++; $display("FAIL spurious_route: r0v=%b r1v=%b, expected 0 0", r0_readdatavalid, r1_readdatavalid);
    end
    @(posedge clk); #1;
    m_readdatavalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin
      n_mis++; $display("FAIL spurious_err: err=%b, expected 1", err);
    end
    repeat ($urandom_range(3, 6)) begin @(posedge clk); #1; end
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin
      n_mis++; $display("FAIL spurious_sticky: err=%b, expected 1", err);
    end
    @(posedge clk); #1;
    pulse_reset();
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0) begin
      n_mis++; $display("FAIL spurious_clear: err=%b, expected 0 after rst", err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_pending();
    bit ok;
    int ids[3] = '{0, 1, 0};
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      req_cmd(ids[i], 1'b1, 1'b0, 25'h600 + 25'(i), 32'h0, ok);
      set_req(ids[i], 0, 0, '0, '0);
      n_cmp++;
      if (!ok) begin
        n_mis++; $display("FAIL pending_issue: read %0d not accepted, expected accept", i);
      end
    end
    set_req(1, 1, 0, 25'h700, 32'h0);   // held request at reset time
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(1, 0, 0, '0, '0);
    m_readdatavalid = 1'b1;             // would route if tags survived
    m_readdata      = 32'h1234_5678;
    @(negedge clk);
    n_cmp++;
    if (m_read !== 1'b0 || m_write !== 1'b0 || r0_waitrequest !== 1'b1 || r1_waitrequest !== 1'b1) begin
      n_mis++; $display("FAIL pending_outputs: m_rd=%b m_wr=%b w0=%b w1=%b, expected 0 0 1 1",
                        m_read, m_write, r0_waitrequest, r1_waitrequest);
    end
    n_cmp++;
    if (r0_readdatavalid !== 1'b0 || r1_readdatavalid !== 1'b0) begin
      n_mis++; $display("FAIL pending_flush: r0v=%b r1v=%b, expected 0 0 (tags discarded)",
                        r0_readdatavalid, r1_readdatavalid);
    end
    @(posedge clk); #1;
    m_readdatavalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin
      n_mis++; $display("FAIL pending_empty: err=%b, expected 1 (count was 0)", err);
    end
    @(posedge clk); #1;
    pulse_reset();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    m_waitrequest = 1'b0;
    m_readdatavalid = 1'b0;
    m_readdata = '0;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    @(posedge clk); #1;
    test_reset();
    test_single_read();
    test_contention();
    test_interleave();
    test_full();
    test_spurious();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
